// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive buffer.
// Frame layout: bit START_BIT = start (expected 0), bits DATA_MSB:DATA_LSB = data
// (LSB first on the wire), bit STOP_BIT = stop (expected 1).
package uart_rx_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAME_W   = 10;
    localparam int unsigned START_BIT = 0;
    localparam int unsigned STOP_BIT  = 9;
    localparam int unsigned DATA_LSB  = 1;
    localparam int unsigned DATA_MSB  = 8;

    typedef struct packed {
        logic              ferr;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    // Split a raw frame into its payload and a start/stop framing-error flag.
    function automatic rx_entry_t check_frame(input logic [FRAME_W-1:0] frame);
        rx_entry_t e;
        e.ferr = (frame[START_BIT] != 1'b0) || (frame[STOP_BIT] != 1'b1);
        e.data = frame[DATA_MSB:DATA_LSB];
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_fifo.sv
// rx_sync_fifo: DEPTH-entry synchronous FIFO of rx_entry_t.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, push_entry  - write request and entry (accepted if not full, or full with a pop)
//   pop_req           - read request (ignored while empty)
//   rd_entry          - registered head entry, loaded on an accepted pop
//   rd_valid          - one-cycle pulse after an accepted pop
//   level             - occupancy; empty/full derive from it
//   empty, full       - occupancy flags
//   push_dropped      - push rejected because the FIFO was full without a pop
module rx_sync_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rx_entry_t                push_entry,
    input  logic                     pop_req,
    output rx_entry_t                rd_entry,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     push_dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    rx_entry_t       mem_q [DEPTH];
    rx_entry_t       mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    rx_entry_t       rd_entry_q, rd_entry_d;
    logic            rd_valid_q, rd_valid_d;
    logic            do_push, do_pop;

    always_comb begin
        empty        = (level_q == '0);
        full         = (level_q == FULL_LVL);
        do_pop       = pop_req && !empty;
        // When full, a same-cycle pop frees the head slot, which is also the tail slot.
        do_push      = push && (!full || do_pop);
        push_dropped = push && full && !do_pop;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_entry_d = rd_entry_q;
        rd_valid_d = do_pop;
        level_d    = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_entry_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_entry_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_entry_q <= rd_entry_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage needs no reset; occupancy decides what is readable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_entry = rd_entry_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: stages completed UART frames, checks start/stop bits and
// buffers {ferr, data} in rx_sync_fifo for the LSU read port.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   frame_valid, frame_in  - completed frame strobe and frame bits
//   rd_req                 - pop request
//   clr_err                - clears overrun and ferr_cnt (a same-edge new event wins)
//   rd_data, rd_ferr       - registered popped byte and its framing-error flag
//   rd_valid               - one-cycle pulse after a pop
//   rx_empty, rx_full      - occupancy flags
//   rx_level               - occupancy
//   overrun                - sticky: a frame was dropped on a full FIFO
//   ferr_cnt               - saturating count of framing errors
//   irq                    - only with UART_RX_BUFFER_IRQ_EN defined:
//                            registered (rx_level >= IRQ_LEVEL) || overrun
module uart_rx_buffer
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_W    = uart_rx_pkg::DATA_W,
    parameter int unsigned FRAME_W   = uart_rx_pkg::FRAME_W,
    parameter int unsigned IRQ_LEVEL = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_valid,
    input  logic [FRAME_W-1:0]       frame_in,
    input  logic                     rd_req,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_ferr,
    output logic                     rd_valid,
    output logic                     rx_empty,
    output logic                     rx_full,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     overrun,
    output logic [7:0]               ferr_cnt
`ifdef UART_RX_BUFFER_IRQ_EN
    ,
    output logic                     irq
`endif
);

    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
        $error("uart_rx_buffer: IRQ_LEVEL must be in 1..DEPTH");
    end

    logic      stg_valid_q, stg_valid_d;
    rx_entry_t stg_entry_q, stg_entry_d;
    logic      overrun_q, overrun_d;
    logic [7:0] ferr_cnt_q, ferr_cnt_d;
    logic      new_err;
    logic      push_dropped;
    rx_entry_t fifo_rd_entry;

    always_comb begin
        stg_valid_d = frame_valid;
        stg_entry_d = frame_valid ? check_frame(frame_in) : stg_entry_q;

        // Errors are counted at the write edge, including frames dropped on full.
        new_err = stg_valid_q && stg_entry_q.ferr;

        overrun_d = overrun_q;
        if (push_dropped) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end

        ferr_cnt_d = ferr_cnt_q;
        if (new_err) begin
            if (clr_err) begin
                ferr_cnt_d = 8'd1;
            end else if (ferr_cnt_q != 8'hFF) begin
                ferr_cnt_d = ferr_cnt_q + 8'd1;
            end
        end else if (clr_err) begin
            ferr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_entry_q <= '0;
            overrun_q   <= 1'b0;
            ferr_cnt_q  <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_entry_q <= stg_entry_d;
            overrun_q   <= overrun_d;
            ferr_cnt_q  <= ferr_cnt_d;
        end
    end

    rx_sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (stg_valid_q),
        .push_entry  (stg_entry_q),
        .pop_req     (rd_req),
        .rd_entry    (fifo_rd_entry),
        .rd_valid    (rd_valid),
        .level       (rx_level),
        .empty       (rx_empty),
        .full        (rx_full),
        .push_dropped(push_dropped)
    );

    assign rd_data  = fifo_rd_entry.data;
    assign rd_ferr  = fifo_rd_entry.ferr;
    assign overrun  = overrun_q;
    assign ferr_cnt = ferr_cnt_q;

`ifdef UART_RX_BUFFER_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (32'(rx_level) >= IRQ_LEVEL) || overrun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: queue-based reference model compared every cycle,
// plus hand-computed literal expectations at key points.
module tb_uart_rx_buffer;

    localparam int DEPTH     = 16;
    localparam int IRQ_LEVEL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_valid = 1'b0;
    logic [9:0] frame_in = '0;
    logic       rd_req = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_ferr;
    logic       rd_valid;
    logic       rx_empty;
    logic       rx_full;
    logic [4:0] rx_level;
    logic       overrun;
    logic [7:0] ferr_cnt;
`ifdef UART_RX_BUFFER_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    uart_rx_buffer #(
        .DEPTH    (DEPTH),
        .DATA_W   (8),
        .FRAME_W  (10),
        .IRQ_LEVEL(IRQ_LEVEL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame_in   (frame_in),
        .rd_req     (rd_req),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .rd_ferr    (rd_ferr),
        .rd_valid   (rd_valid),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_level   (rx_level),
        .overrun    (overrun),
        .ferr_cnt   (ferr_cnt)
`ifdef UART_RX_BUFFER_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [8:0] q[$];
    bit       m_stg_v = 1'b0;
    bit [8:0] m_stg = '0;
    bit       m_ovr = 1'b0;
    int       m_fcnt = 0;
    bit [7:0] m_rd_data = '0;
    bit       m_rd_ferr = 1'b0;
    bit       m_rd_valid = 1'b0;
    bit       m_irq = 1'b0;

    always @(posedge clk) begin : model
        int n;
        bit pop;
        bit drop;
        bit err;
        bit [8:0] head;
        if (rst) begin
            q.delete();
            m_stg_v = 1'b0;
            m_ovr = 1'b0;
            m_fcnt = 0;
            m_rd_data = '0;
            m_rd_ferr = 1'b0;
            m_rd_valid = 1'b0;
            m_irq = 1'b0;
        end else begin
            n = q.size();
            pop = rd_req && (n > 0);
            m_irq = (n >= IRQ_LEVEL) || m_ovr;
            if (pop) begin
                head = q.pop_front();
                m_rd_ferr = head[8];
                m_rd_data = head[7:0];
            end
            m_rd_valid = pop;
            drop = 1'b0;
            err = 1'b0;
            if (m_stg_v) begin
                if (n < DEPTH || pop) q.push_back(m_stg);
                else drop = 1'b1;
                err = m_stg[8];
            end
            if (drop) m_ovr = 1'b1;
            else if (clr_err) m_ovr = 1'b0;
            if (err) m_fcnt = clr_err ? 1 : (m_fcnt < 255 ? m_fcnt + 1 : 255);
            else if (clr_err) m_fcnt = 0;
            m_stg_v = frame_valid;
            m_stg = {(frame_in[0] != 1'b0) || (frame_in[9] != 1'b1), frame_in[8:1]};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("rd_data",  32'(rd_data),  32'(m_rd_data));
            chk("rd_ferr",  32'(rd_ferr),  32'(m_rd_ferr));
            chk("rx_level", 32'(rx_level), 32'(q.size()));
            chk("rx_empty", 32'(rx_empty), 32'(q.size() == 0));
            chk("rx_full",  32'(rx_full),  32'(q.size() == DEPTH));
            chk("overrun",  32'(overrun),  32'(m_ovr));
            chk("ferr_cnt", 32'(ferr_cnt), 32'(m_fcnt));
`ifdef UART_RX_BUFFER_IRQ_EN
            chk("irq",      32'(irq),      32'(m_irq));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] f);
        frame_in = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    function automatic logic [9:0] mk(input logic [7:0] d, input logic start, input logic stop);
        return {stop, d, start};
    endfunction

    initial begin
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_level", 32'(rx_level), 32'd0);
        chk("rst_empty", 32'(rx_empty), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // 1: good frame, 2-cycle write latency, pop
        send(10'b1_10100101_0);
        tick();
        @(negedge clk);
        chk("t1_level", 32'(rx_level), 32'd1);
        chk("t1_empty", 32'(rx_empty), 32'd0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t1_rd_valid", 32'(rd_valid), 32'd1);
        chk("t1_rd_data", 32'(rd_data), 32'hA5);
        chk("t1_rd_ferr", 32'(rd_ferr), 32'd0);
        chk("t1_empty2", 32'(rx_empty), 32'd1);

        // 2: bad stop bit, plus a bad start bit
        send(10'b0_00111100_0);
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t2_rd_data", 32'(rd_data), 32'h3C);
        chk("t2_rd_ferr", 32'(rd_ferr), 32'd1);
        chk("t2_ferr_cnt", 32'(ferr_cnt), 32'd1);
        send(mk(8'h5A, 1'b1, 1'b1));
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t2_start_ferr", 32'(rd_ferr), 32'd1);
        chk("t2_ferr_cnt2", 32'(ferr_cnt), 32'd2);

        // 3: overflow with DEPTH+1 frames, ordered drain, clr_err
        for (int i = 0; i <= DEPTH; i++) send(mk(8'(i), 1'b0, 1'b1));
        tick();
        @(negedge clk);
        chk("t3_full", 32'(rx_full), 32'd1);
        chk("t3_level", 32'(rx_level), 32'd16);
        chk("t3_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1'b1;
            tick();
            @(negedge clk);
            chk("t3_order", 32'(rd_data), 32'(i));
        end
        rd_req = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        chk("t3_clr_ovr", 32'(overrun), 32'd0);
        chk("t3_clr_fcnt", 32'(ferr_cnt), 32'd0);

        // 4: write into full FIFO coinciding with a pop
        for (int i = 0; i < DEPTH; i++) send(mk(8'(8'h40 + i), 1'b0, 1'b1));
        tick();
        send(mk(8'hEE, 1'b0, 1'b1));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t4_level", 32'(rx_level), 32'd16);
        chk("t4_overrun", 32'(overrun), 32'd0);
        chk("t4_rd_data", 32'(rd_data), 32'h40);
        rd_req = 1'b1;
        repeat (DEPTH) tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t4_last", 32'(rd_data), 32'hEE);
        chk("t4_empty", 32'(rx_empty), 32'd1);

        // 5: pop while empty, then reset with a staged frame
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("t5_rd_valid", 32'(rd_valid), 32'd0);
        chk("t5_level", 32'(rx_level), 32'd0);
        chk("t5_hold", 32'(rd_data), 32'hEE);
        send(mk(8'h11, 1'b0, 1'b1));
        send(mk(8'h22, 1'b0, 1'b0));
        send(mk(8'h33, 1'b0, 1'b1));
        send(mk(8'h44, 1'b0, 1'b1));
        send(mk(8'h55, 1'b0, 1'b1));
        send(mk(8'h66, 1'b0, 1'b1));
        @(negedge clk);
        chk("t5_pre_level", 32'(rx_level), 32'd5);
        chk("t5_pre_fcnt", 32'(ferr_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_level", 32'(rx_level), 32'd0);
        chk("t5_rst_empty", 32'(rx_empty), 32'd1);
        chk("t5_rst_rd_data", 32'(rd_data), 32'd0);
        chk("t5_rst_fcnt", 32'(ferr_cnt), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("t5_no_stage", 32'(rx_level), 32'd0);

        // ferr_cnt saturation, then clr_err coinciding with a new error and a drop
        for (int i = 0; i < 300; i++) send(mk(8'(i), 1'b1, 1'b1));
        tick();
        @(negedge clk);
        chk("sat_fcnt", 32'(ferr_cnt), 32'd255);
        chk("sat_overrun", 32'(overrun), 32'd1);
        send(mk(8'h77, 1'b0, 1'b0));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_vs_err", 32'(ferr_cnt), 32'd1);
        chk("clr_vs_drop", 32'(overrun), 32'd1);

        // 6: irq threshold
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(mk(8'(8'h80 + i), 1'b0, 1'b1));
        tick();
        @(negedge clk);
        chk("t6_level8", 32'(rx_level), 32'd8);
`ifdef UART_RX_BUFFER_IRQ_EN
        chk("t6_irq_lag", 32'(irq), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_irq_rise", 32'(irq), 32'd1);
`endif
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_level7", 32'(rx_level), 32'd7);
`ifdef UART_RX_BUFFER_IRQ_EN
        chk("t6_irq_fall", 32'(irq), 32'd0);
`endif
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
